// File: rtl/interval_capture_if.sv
// Handshake bundle for interval_capture: measurement events in, result and status out.
interface interval_capture_if #(
  parameter int unsigned CNT_W = 21
);
  logic             start;
  logic             stop;
  logic             ack;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic             timeout;
  logic             busy;

  modport master (output start, stop, ack, input count, valid, timeout, busy);
  modport slave  (input start, stop, ack, output count, valid, timeout, busy);
endinterface

// File: rtl/interval_capture.sv
// Counts clk cycles from a START event to a STOP event, bounded by MAX_COUNT,
// and holds the result on a VALID/ACK handshake.
//
//   state   | meaning
//   IDLE    | waiting for start
//   MEASURE | counting cycles until stop or the limit
//   HOLD    | result presented, waiting for ack
module interval_capture #(
  parameter int unsigned      CNT_W     = 21,
  parameter logic [CNT_W-1:0] MAX_COUNT = CNT_W'(21'h1F_FFFF)
) (
  input logic               clk,
  input logic               rst,
  input logic               clr,
  interval_capture_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             timeout_q;
  logic             busy_q;
  logic [CNT_W-1:0] n;

  // counter stays below MAX_COUNT, so this increment cannot wrap
  assign n = counter + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state     <= IDLE;
      counter   <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            counter <= '0;
            busy_q  <= 1'b1;
            state   <= MEASURE;
          end
        end
        MEASURE: begin
          if (bus.stop) begin
            count_q   <= n;
            valid_q   <= 1'b1;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            state     <= HOLD;
          end else if (n == MAX_COUNT) begin
            count_q   <= MAX_COUNT;
            valid_q   <= 1'b1;
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state     <= HOLD;
          end else begin
            counter <= n;
          end
        end
        HOLD: begin
          if (bus.ack) begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          valid_q   <= 1'b0;
          timeout_q <= 1'b0;
          busy_q    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.valid   = valid_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_interval_capture.sv
// Directed and randomized bench for interval_capture with a small MAX_COUNT so
// timeouts are reachable; expected results come from the min(k, MAX) rule.
module tb_interval_capture;
  localparam int unsigned CNT_W = 21;
  localparam int          MAX   = 8;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_last = 0;

  interval_capture_if #(.CNT_W(CNT_W)) ifc ();

  interval_capture #(.CNT_W(CNT_W), .MAX_COUNT(CNT_W'(MAX))) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Start a measurement from IDLE; stop k edges after the start edge when use_stop.
  task automatic measure(input int k, input bit use_stop, input bit stop_with_start);
    bit hit;
    int exp_edge;
    hit      = use_stop && (k <= MAX);
    exp_edge = hit ? k : MAX;
    ifc.start = 1'b1;
    ifc.stop  = stop_with_start;
    step();
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    check("busy_after_start", 32'(ifc.busy), 1);
    check("valid_after_start", 32'(ifc.valid), 0);
    for (int i = 1; i <= exp_edge; i++) begin
      ifc.stop  = use_stop && (i == k);
      ifc.ack   = 1'($urandom_range(0, 1));
      ifc.start = 1'($urandom_range(0, 1));
      step();
      ifc.stop  = 1'b0;
      ifc.ack   = 1'b0;
      ifc.start = 1'b0;
      if (i < exp_edge) begin
        check("valid_early", 32'(ifc.valid), 0);
        check("busy_measuring", 32'(ifc.busy), 1);
      end
    end
    exp_last = exp_edge;
    check("valid_result", 32'(ifc.valid), 1);
    check("count_result", 32'(ifc.count), 32'(exp_last));
    check("timeout_result", 32'(ifc.timeout), 32'(!hit));
    check("busy_in_hold", 32'(ifc.busy), 0);
  endtask

  // Hold for some cycles with start noise, then ack (possibly with start on the same cycle).
  task automatic release_hold(input int cycles);
    for (int j = 0; j < cycles; j++) begin
      ifc.start = 1'($urandom_range(0, 1));
      step();
      ifc.start = 1'b0;
      check("hold_valid", 32'(ifc.valid), 1);
      check("hold_count", 32'(ifc.count), 32'(exp_last));
      check("hold_busy", 32'(ifc.busy), 0);
    end
    ifc.ack   = 1'b1;
    ifc.start = 1'($urandom_range(0, 1));
    step();
    ifc.ack   = 1'b0;
    ifc.start = 1'b0;
    check("ack_valid", 32'(ifc.valid), 0);
    check("ack_timeout", 32'(ifc.timeout), 0);
    check("ack_count_kept", 32'(ifc.count), 32'(exp_last));
    step();
    check("no_start_on_ack", 32'(ifc.busy), 0);
  endtask

  task automatic abort(input bit use_clr, input bit in_hold);
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if (in_hold) begin
      ifc.stop = 1'b1;
      step();
      ifc.stop = 1'b0;
      check("abort_pre_valid", 32'(ifc.valid), 1);
    end else begin
      check("abort_pre_busy", 32'(ifc.busy), 1);
    end
    if (use_clr) clr = 1'b1; else rst = 1'b1;
    step();
    clr = 1'b0;
    rst = 1'b0;
    exp_last = 0;
    check("abort_valid", 32'(ifc.valid), 0);
    check("abort_busy", 32'(ifc.busy), 0);
    check("abort_count", 32'(ifc.count), 0);
    check("abort_timeout", 32'(ifc.timeout), 0);
    for (int i = 0; i < MAX + 2; i++) begin
      step();
      check("abort_no_valid", 32'(ifc.valid), 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    ifc.start = 1'b0;
    ifc.stop  = 1'b0;
    ifc.ack   = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 32'(ifc.valid), 0);
    check("rst_busy", 32'(ifc.busy), 0);
    check("rst_count", 32'(ifc.count), 0);
    check("rst_timeout", 32'(ifc.timeout), 0);

    // stop and ack while idle do nothing
    ifc.stop = 1'b1;
    ifc.ack  = 1'b1;
    step();
    ifc.stop = 1'b0;
    ifc.ack  = 1'b0;
    check("idle_ignore_busy", 32'(ifc.busy), 0);
    check("idle_ignore_valid", 32'(ifc.valid), 0);

    measure(5, 1'b1, 1'b0);
    release_hold(2);
    measure(1, 1'b1, 1'b0);
    release_hold(0);
    measure(3, 1'b1, 1'b1);
    release_hold(1);
    measure(12, 1'b0, 1'b0);
    release_hold(1);
    measure(MAX, 1'b1, 1'b0);
    release_hold(0);
    measure(6, 1'b1, 1'b0);
    release_hold(10);

    abort(1'b0, 1'b0);
    abort(1'b1, 1'b0);
    abort(1'b0, 1'b1);
    abort(1'b1, 1'b1);

    measure(3, 1'b1, 1'b0);
    release_hold(0);
    measure(7, 1'b1, 1'b0);
    release_hold(0);
    measure(1, 1'b1, 1'b0);
    release_hold(0);

    for (int r = 0; r < 25; r++) begin
      measure(int'($urandom_range(1, 12)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));
      release_hold(int'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
